// File: rtl/clkmeas_pkg.sv
// Shared types and helpers for the clkmeas frequency counter.
package clkmeas_pkg;

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} t_clkmeas_state;

  typedef struct packed {
    logic        ovf;
    logic [63:0] val;
  } t_sat_res;

  function automatic int unsigned calc_window(input int unsigned main_hz,
                                              input int unsigned gate_hz);
    return main_hz / gate_hz;
  endfunction

  // Product is formed at 64 bits, wide enough for a 32-bit count times a
  // 32-bit rate, then clamped to the all-ones value of a 'bits'-wide result.
  function automatic t_sat_res sat_mul(input logic [63:0] cnt,
                                       input logic [63:0] rate,
                                       input int unsigned bits);
    logic [63:0] prod;
    logic [63:0] max_val;
    t_sat_res    res;
    prod    = cnt * rate;
    max_val = (bits >= 64) ? '1 : ((64'd1 << bits) - 64'd1);
    res.ovf = (prod > max_val);
    res.val = res.ovf ? max_val : prod;
    return res;
  endfunction

endpackage

// File: rtl/clkmeas_sigsync.sv
// Synchronizer, optional glitch filter (CLKMEAS_GLITCH_FILTER_EN) and
// rising-edge detector; 'rise' is a one-cycle pulse per accepted edge.
module sigsync #(
  parameter int SYNC_STAGES = 2
`ifdef CLKMEAS_GLITCH_FILTER_EN
  ,
  parameter int FILT_LEN    = 3
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   level;
  logic                   prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], sig};
  end

  assign synced = sync_q[SYNC_STAGES-1];

`ifdef CLKMEAS_GLITCH_FILTER_EN
  // Level flips only once the current and previous FILT_LEN-1 samples agree.
  logic [FILT_LEN-2:0] hist_q;
  logic                filt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      filt_q <= 1'b0;
    end else begin
      hist_q <= (hist_q << 1) | (FILT_LEN-1)'(synced);
      if (&{hist_q, synced})       filt_q <= 1'b1;
      else if (~|{hist_q, synced}) filt_q <= 1'b0;
    end
  end

  assign level = filt_q;
`else
  assign level = synced;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= level;
  end

  assign rise = level & ~prev_q;

endmodule

// File: rtl/clkmeas.sv
// Gate-window frequency counter for a slow asynchronous input.
// Optional glitch filter enabled by defining CLKMEAS_GLITCH_FILTER_EN.
module clkmeas
  import clkmeas_pkg::*;
#(
  parameter int unsigned MAIN_CLK_HZ = 50_000_000,
  parameter int unsigned GATE_HZ     = 10,
  parameter int          CTR_BITS    = 32,
  parameter int          SYNC_STAGES = 2,
  parameter int          FILT_LEN    = 3
) (
  input  logic                in_clk,
  input  logic                in_rst,
  input  logic                in_enable,
  input  logic                in_sig,
  output logic [CTR_BITS-1:0] out_freq,
  output logic                out_valid,
  output logic                out_stuck,
  output logic                out_overflow,
  output logic                out_busy
);

`ifdef CLKMEAS_GLITCH_FILTER_EN
  localparam int FILT_DELAY = FILT_LEN;
`else
  localparam int FILT_DELAY = 0 * FILT_LEN;
`endif

  localparam int unsigned WINDOW  = calc_window(MAIN_CLK_HZ, GATE_HZ);
  localparam int          GATE_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int          ARM_LEN = SYNC_STAGES + FILT_DELAY + 1;
  localparam int          ARM_W   = $clog2(ARM_LEN + 1);

  t_clkmeas_state       state_q, state_d;
  logic [ARM_W-1:0]     arm_ctr;
  logic [GATE_W-1:0]    gate_ctr;
  logic [CTR_BITS-1:0]  edge_ctr, edge_next;
  logic                 edge_sat, edge_sat_next;
  logic                 rise, arm_done, window_end;
  t_sat_res             mul_res;
  logic [CTR_BITS-1:0]  freq_next;
  logic [63-CTR_BITS:0] unused_hi;

`ifdef CLKMEAS_GLITCH_FILTER_EN
  sigsync #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sigsync (
`else
  sigsync #(.SYNC_STAGES(SYNC_STAGES)) u_sigsync (
`endif
    .clk  (in_clk),
    .rst  (in_rst),
    .sig  (in_sig),
    .rise (rise)
  );

  assign arm_done   = (arm_ctr == ARM_W'(ARM_LEN - 1));
  assign window_end = (state_q == MEASURE) && in_enable &&
                      (gate_ctr == GATE_W'(WINDOW - 1));

  // Edge count saturates instead of wrapping; an edge on the final window
  // cycle is folded into the result through edge_next.
  assign edge_next     = (rise && (edge_ctr != '1)) ? edge_ctr + 1'b1 : edge_ctr;
  assign edge_sat_next = edge_sat | (rise && (edge_ctr == '1));

  assign mul_res = sat_mul(64'(edge_next), 64'(GATE_HZ), CTR_BITS);
  assign {unused_hi, freq_next} = mul_res.val;

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_enable) state_d = ARM;
      ARM:     if (!in_enable) state_d = IDLE;
               else if (arm_done) state_d = MEASURE;
      MEASURE: if (!in_enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      arm_ctr      <= '0;
      gate_ctr     <= '0;
      edge_ctr     <= '0;
      edge_sat     <= 1'b0;
      out_freq     <= '0;
      out_valid    <= 1'b0;
      out_stuck    <= 1'b0;
      out_overflow <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (state_q == ARM) begin
        arm_ctr  <= arm_ctr + 1'b1;
        gate_ctr <= '0;
        edge_ctr <= '0;
        edge_sat <= 1'b0;
      end else begin
        arm_ctr <= '0;
        if (window_end) begin
          gate_ctr     <= '0;
          edge_ctr     <= '0;
          edge_sat     <= 1'b0;
          out_freq     <= freq_next;
          out_stuck    <= (edge_next == '0);
          out_overflow <= mul_res.ovf | edge_sat_next;
          out_valid    <= 1'b1;
        end else if (state_q == MEASURE) begin
          gate_ctr <= gate_ctr + 1'b1;
          edge_ctr <= edge_next;
          edge_sat <= edge_sat_next;
        end
      end
    end
  end

  assign out_busy = (state_q != IDLE);

endmodule

// File: tb/tb_clkmeas.sv
// Scoreboard bench for clkmeas at MAIN_CLK_HZ=1000, GATE_HZ=10 (100-cycle window).
module tb_clkmeas;

  localparam int WINDOW = 100;
`ifdef CLKMEAS_GLITCH_FILTER_EN
  localparam int ARM_LEN = 2 + 3 + 1;
`else
  localparam int ARM_LEN = 2 + 1;
`endif
  // enable sampled on first edge, ARM_LEN arm cycles, WINDOW cycles, then the registered strobe
  localparam int FIRST_LAT = 1 + ARM_LEN + WINDOW;

  typedef struct packed {
    logic [31:0] freq;
    logic        stuck;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  exp_t sat_q[$];
  exp_t e_main, e_sat;

  int n_checks = 0;
  int n_fail   = 0;

  logic        clk = 1'b0;
  logic        rst, enable, sat_enable, sig;
  logic [31:0] freq;
  logic        valid, stuck, ovf, busy;
  logic [6:0]  sat_freq;
  logic        sat_valid, sat_stuck, sat_ovf, sat_busy;

  int sig_mode = 0;
  int sig_half = 5;
  int sig_ph   = 0;

  always #5 clk = ~clk;

  clkmeas #(.MAIN_CLK_HZ(1000), .GATE_HZ(10), .CTR_BITS(32),
            .SYNC_STAGES(2), .FILT_LEN(3)) dut (
    .in_clk(clk), .in_rst(rst), .in_enable(enable), .in_sig(sig),
    .out_freq(freq), .out_valid(valid), .out_stuck(stuck),
    .out_overflow(ovf), .out_busy(busy)
  );

  clkmeas #(.MAIN_CLK_HZ(1000), .GATE_HZ(10), .CTR_BITS(7),
            .SYNC_STAGES(2), .FILT_LEN(3)) dut_sat (
    .in_clk(clk), .in_rst(rst), .in_enable(sat_enable), .in_sig(sig),
    .out_freq(sat_freq), .out_valid(sat_valid), .out_stuck(sat_stuck),
    .out_overflow(sat_ovf), .out_busy(sat_busy)
  );

  // Modes: 0 low, 1 high, 2 square wave of period 2*sig_half, 3 one-cycle pulse every 20
  initial begin
    sig = 1'b0;
    forever begin
      @(negedge clk);
      sig_ph++;
      case (sig_mode)
        0: sig = 1'b0;
        1: sig = 1'b1;
        2: if (sig_ph >= sig_half) begin sig_ph = 0; sig = ~sig; end
        default: begin
          if (sig_ph >= 20) sig_ph = 0;
          sig = (sig_ph == 0);
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL main_unexpected_valid: got freq=%0d stuck=%0b ovf=%0b, required no out_valid",
                 freq, stuck, ovf);
      end else begin
        e_main = exp_q.pop_front();
        if ({freq, stuck, ovf} !== {e_main.freq, e_main.stuck, e_main.ovf}) begin
          n_fail++;
          $display("FAIL main_result: got freq=%0d stuck=%0b ovf=%0b, required freq=%0d stuck=%0b ovf=%0b",
                   freq, stuck, ovf, e_main.freq, e_main.stuck, e_main.ovf);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (sat_valid) begin
      n_checks++;
      if (sat_q.size() == 0) begin
        n_fail++;
        $display("FAIL sat_unexpected_valid: got freq=%0d, required no out_valid", sat_freq);
      end else begin
        e_sat = sat_q.pop_front();
        if ({32'(sat_freq), sat_stuck, sat_ovf} !== {e_sat.freq, e_sat.stuck, e_sat.ovf}) begin
          n_fail++;
          $display("FAIL sat_result: got freq=%0d stuck=%0b ovf=%0b, required freq=%0d stuck=%0b ovf=%0b",
                   sat_freq, sat_stuck, sat_ovf, e_sat.freq, e_sat.stuck, e_sat.ovf);
        end
      end
    end
  end

  task automatic wait_valid(input bit use_sat, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!(use_sat ? sat_valid : valid) && cycles < 1000);
    if (!(use_sat ? sat_valid : valid)) cycles = -1;
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b0; sat_enable = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({freq, valid, stuck, ovf, busy} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got freq=%0d valid=%0b stuck=%0b ovf=%0b busy=%0b, required all 0",
               freq, valid, stuck, ovf, busy);
    end
    n_checks++;
    if ({sat_freq, sat_valid, sat_stuck, sat_ovf, sat_busy} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_sat_outputs: got freq=%0d busy=%0b, required all 0", sat_freq, sat_busy);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_rate;
    int c;
    sig_mode = 2; sig_half = 5;
    repeat (5) @(negedge clk);
    repeat (3) exp_q.push_back('{freq: 32'd100, stuck: 1'b0, ovf: 1'b0});
    enable = 1'b1;
    wait_valid(0, c);
    n_checks++;
    if (c !== FIRST_LAT) begin
      n_fail++; $display("FAIL rate_first_latency: got %0d cycles, required %0d", c, FIRST_LAT);
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL rate_busy: got %0b, required 1", busy);
    end
    repeat (2) begin
      wait_valid(0, c);
      n_checks++;
      if (c !== WINDOW) begin
        n_fail++; $display("FAIL rate_period: got %0d cycles, required %0d", c, WINDOW);
      end
    end
    enable = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL rate_idle_busy: got %0b, required 0", busy);
    end
  endtask

  task automatic test_stuck;
    int c;
    sig_mode = 1;
    repeat (10) @(negedge clk);
    repeat (2) exp_q.push_back('{freq: 32'd0, stuck: 1'b1, ovf: 1'b0});
    enable = 1'b1;
    wait_valid(0, c);
    n_checks++;
    if (c !== FIRST_LAT) begin
      n_fail++; $display("FAIL stuck_latency: got %0d cycles, required %0d", c, FIRST_LAT);
    end
    wait_valid(0, c);
    n_checks++;
    if (c !== WINDOW) begin
      n_fail++; $display("FAIL stuck_period: got %0d cycles, required %0d", c, WINDOW);
    end
    enable = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_saturation;
    int c;
    sig_mode = 2; sig_half = 2;
    repeat (5) @(negedge clk);
    sat_q.push_back('{freq: 32'd127, stuck: 1'b0, ovf: 1'b1});
    sat_enable = 1'b1;
    wait_valid(1, c);
    n_checks++;
    if (c !== FIRST_LAT) begin
      n_fail++; $display("FAIL sat_latency: got %0d cycles, required %0d", c, FIRST_LAT);
    end
    sat_enable = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int c;
    sig_mode = 2; sig_half = 5;
    repeat (5) @(negedge clk);
    exp_q.push_back('{freq: 32'd100, stuck: 1'b0, ovf: 1'b0});
    enable = 1'b1;
    wait_valid(0, c);
    repeat (50) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({freq, valid, stuck, ovf, busy} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got freq=%0d valid=%0b stuck=%0b ovf=%0b busy=%0b, required all 0",
               freq, valid, stuck, ovf, busy);
    end
    exp_q.push_back('{freq: 32'd100, stuck: 1'b0, ovf: 1'b0});
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_valid(0, c);
    n_checks++;
    if (c !== FIRST_LAT) begin
      n_fail++; $display("FAIL reset_mid_relatency: got %0d cycles, required %0d", c, FIRST_LAT);
    end
    enable = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_disable_mid;
    int c;
    exp_q.push_back('{freq: 32'd100, stuck: 1'b0, ovf: 1'b0});
    enable = 1'b1;
    wait_valid(0, c);
    repeat (40) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL disable_busy: got %0b, required 0", busy);
    end
    repeat (150) @(negedge clk);
    n_checks++;
    if (freq !== 32'd100) begin
      n_fail++; $display("FAIL disable_hold_freq: got %0d, required 100", freq);
    end
    exp_q.push_back('{freq: 32'd100, stuck: 1'b0, ovf: 1'b0});
    enable = 1'b1;
    wait_valid(0, c);
    n_checks++;
    if (c !== FIRST_LAT) begin
      n_fail++; $display("FAIL disable_reenable_latency: got %0d cycles, required %0d", c, FIRST_LAT);
    end
    enable = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_glitch;
    int c;
    sig_mode = 3;
    repeat (25) @(negedge clk);
`ifdef CLKMEAS_GLITCH_FILTER_EN
    repeat (2) exp_q.push_back('{freq: 32'd0, stuck: 1'b1, ovf: 1'b0});
`else
    repeat (2) exp_q.push_back('{freq: 32'd50, stuck: 1'b0, ovf: 1'b0});
`endif
    enable = 1'b1;
    repeat (2) begin
      wait_valid(0, c);
      n_checks++;
      if (c < 0) begin
        n_fail++; $display("FAIL glitch_timeout: got no out_valid within 1000 cycles, required one");
      end
    end
    enable = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_rate;
    test_stuck;
    test_saturation;
    test_reset_mid;
    test_disable_mid;
    test_glitch;
    n_checks++;
    if (exp_q.size() != 0 || sat_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending results, required 0/0",
               exp_q.size(), sat_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
